// File: rtl/core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// core_ctrl_fsm
//
// Multi-cycle control unit for the 101core RV32I datapath. Each instruction
// moves through FETCH -> DECODE -> EXECUTE -> (MEM) -> WB. The controller
// drives the ALU opcode and operand selects, the immediate-type select, the
// register-file/PC/IR write enables and the memory request handshake. A
// watchdog aborts any memory request that waits too long; the aborted
// instruction is refetched because the PC is left untouched.
//
// Optional build macro:
//   CORE101_ILLEGAL_TRAP_EN - an unknown opcode in DECODE enters TRAP, which
//                             holds every enable low until reset. When left
//                             undefined, unknown opcodes retire as NOPs.
//
// Parameters:
//   MEM_TIMEOUT     cycles a request may wait for mem_ready_i (1..255)
//
// Ports:
//   CLOCK_50        core clock, rising-edge
//   RESET_N         asynchronous active-low reset
//   ir_i            instruction register contents
//   mem_ready_i     memory completes the outstanding request this cycle
//   branch_taken_i  datapath comparator result, sampled in EXECUTE
//   mem_req_o       memory request
//   mem_we_o        1 = store, 0 = load/fetch
//   mem_addr_sel_o  0 = PC, 1 = ALU result register
//   ir_write_o      capture fetched word into IR
//   pc_write_o      update PC
//   pc_src_sel_o    0 = PC+4, 1 = ALU output
//   alu_opcode_o    {funct7[5], funct3} ALU operation
//   alu_a_sel_o     0 = rs1, 1 = PC, 2 = zero
//   alu_b_sel_o     0 = rs2, 1 = imm, 2 = const 4
//   imm_sel_o       0 = I, 1 = S, 2 = B, 3 = U, 4 = J
//   rf_we_o         register-file write enable
//   wb_sel_o        0 = ALU result, 1 = memory data, 2 = PC+4
//   mem_err_o       one-cycle pulse on memory timeout
//   state_o         FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5
// ---------------------------------------------------------------------------
module core_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        CLOCK_50,
    input  logic        RESET_N,
    input  logic [31:0] ir_i,
    input  logic        mem_ready_i,
    input  logic        branch_taken_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_addr_sel_o,
    output logic        ir_write_o,
    output logic        pc_write_o,
    output logic        pc_src_sel_o,
    output logic [3:0]  alu_opcode_o,
    output logic [1:0]  alu_a_sel_o,
    output logic [1:0]  alu_b_sel_o,
    output logic [2:0]  imm_sel_o,
    output logic        rf_we_o,
    output logic [1:0]  wb_sel_o,
    output logic        mem_err_o,
    output logic [2:0]  state_o
);

    // RV32I major opcodes
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;

    localparam logic [1:0] B_RS2 = 2'd0;
    localparam logic [1:0] B_IMM = 2'd1;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic PC_SRC_SEQ = 1'b0;
    localparam logic PC_SRC_ALU = 1'b1;

    // Last count value before the watchdog fires
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4
`ifdef CORE101_ILLEGAL_TRAP_EN
        , S_TRAP  = 3'd5
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_timeout_cnt;
    logic [7:0]  w_timeout_cnt_next;
    logic        r_abort;
    logic        w_abort_next;
    logic        r_branch_taken;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_funct7b5;
    logic        w_is_op;
    logic        w_is_op_imm;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_lui;
    logic        w_is_auipc;
    logic        w_is_branch;
    logic        w_is_jal;
    logic        w_is_jalr;
    logic        w_is_known;
    logic [2:0]  w_imm_type;
    logic        w_unused_ir;

    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_mem_addr_sel;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_pc_src_sel;
    logic [3:0]  w_alu_opcode;
    logic [1:0]  w_alu_a_sel;
    logic [1:0]  w_alu_b_sel;
    logic [2:0]  w_imm_sel;
    logic        w_rf_we;
    logic [1:0]  w_wb_sel;
    logic        w_timeout;

    // Instruction field decode
    assign w_opcode    = ir_i[6:0];
    assign w_funct3    = ir_i[14:12];
    assign w_funct7b5  = ir_i[30];
    assign w_unused_ir = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

    assign w_is_op     = (w_opcode == OPC_OP);
    assign w_is_op_imm = (w_opcode == OPC_OP_IMM);
    assign w_is_load   = (w_opcode == OPC_LOAD);
    assign w_is_store  = (w_opcode == OPC_STORE);
    assign w_is_lui    = (w_opcode == OPC_LUI);
    assign w_is_auipc  = (w_opcode == OPC_AUIPC);
    assign w_is_branch = (w_opcode == OPC_BRANCH);
    assign w_is_jal    = (w_opcode == OPC_JAL);
    assign w_is_jalr   = (w_opcode == OPC_JALR);
    assign w_is_known  = w_is_op | w_is_op_imm | w_is_load | w_is_store |
                         w_is_lui | w_is_auipc | w_is_branch | w_is_jal | w_is_jalr;

    // Immediate format follows the opcode; unknown and R-type fall back to I
    always_comb begin
        w_imm_type = IMM_I;
        if (w_is_store)
            w_imm_type = IMM_S;
        else if (w_is_branch)
            w_imm_type = IMM_B;
        else if (w_is_lui || w_is_auipc)
            w_imm_type = IMM_U;
        else if (w_is_jal)
            w_imm_type = IMM_J;
    end

    // State, watchdog counter, abort flag and the branch decision latched
    // in EXECUTE for use in WB
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= S_FETCH;
            r_timeout_cnt  <= 8'd0;
            r_abort        <= 1'b0;
            r_branch_taken <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_timeout_cnt <= w_timeout_cnt_next;
            r_abort       <= w_abort_next;
            if (r_state == S_EXECUTE && w_is_branch)
                r_branch_taken <= branch_taken_i;
        end
    end

    // The watchdog fires on the cycle the counter sits at its last value
    // with the request still up. It takes priority over a late ready so an
    // abort is never half-completed.
    assign w_timeout = w_mem_req && (r_timeout_cnt == TIMEOUT_LAST);

    always_comb begin
        w_timeout_cnt_next = 8'd0;
        if (w_mem_req && !mem_ready_i && !w_timeout)
            w_timeout_cnt_next = r_timeout_cnt + 8'd1;
    end

    // Next-state logic. After a timeout the FSM parks in FETCH for one
    // cycle with the request dropped (r_abort) before refetching.
    always_comb begin
        w_state_next = r_state;
        w_abort_next = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (r_abort) begin
                    w_state_next = S_FETCH;
                end else if (w_timeout) begin
                    w_state_next = S_FETCH;
                    w_abort_next = 1'b1;
                end else if (mem_ready_i) begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
`ifdef CORE101_ILLEGAL_TRAP_EN
                if (w_is_known)
                    w_state_next = S_EXECUTE;
                else
                    w_state_next = S_TRAP;
`else
                w_state_next = S_EXECUTE;
`endif
            end
            S_EXECUTE: begin
                if (w_is_load || w_is_store)
                    w_state_next = S_MEM;
                else
                    w_state_next = S_WB;
            end
            S_MEM: begin
                if (w_timeout) begin
                    w_state_next = S_FETCH;
                    w_abort_next = 1'b1;
                end else if (mem_ready_i) begin
                    w_state_next = S_WB;
                end
            end
            S_WB: begin
                w_state_next = S_FETCH;
            end
`ifdef CORE101_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_state_next = S_TRAP;
            end
`endif
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    // Moore output decode from registered state and the current IR.
    // ir_write is the only output allowed to follow mem_ready_i directly.
    always_comb begin
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_write     = 1'b0;
        w_pc_write     = 1'b0;
        w_pc_src_sel   = PC_SRC_SEQ;
        w_alu_opcode   = ALU_ADD;
        w_alu_a_sel    = A_RS1;
        w_alu_b_sel    = B_RS2;
        w_imm_sel      = IMM_I;
        w_rf_we        = 1'b0;
        w_wb_sel       = WB_ALU;
        case (r_state)
            S_FETCH: begin
                w_mem_req = !r_abort;
            end
            S_DECODE: begin
                w_imm_sel = w_imm_type;
            end
            S_EXECUTE: begin
                w_imm_sel = w_imm_type;
                if (w_is_op) begin
                    w_alu_opcode = {w_funct7b5, w_funct3};
                end else if (w_is_op_imm) begin
                    // Only SRAI carries an opcode bit in funct7; for the
                    // other immediates bit 30 is part of the constant
                    w_alu_opcode = {(w_funct3 == 3'b101) && w_funct7b5, w_funct3};
                    w_alu_b_sel  = B_IMM;
                end else if (w_is_load || w_is_store) begin
                    w_alu_b_sel = B_IMM;
                end else if (w_is_lui) begin
                    w_alu_a_sel = A_ZERO;
                    w_alu_b_sel = B_IMM;
                end else if (w_is_auipc) begin
                    w_alu_a_sel = A_PC;
                    w_alu_b_sel = B_IMM;
                end else if (w_is_branch) begin
                    w_alu_opcode = ALU_SUB;
                end
            end
            S_MEM: begin
                w_imm_sel      = w_imm_type;
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = w_is_store;
            end
            S_WB: begin
                w_imm_sel  = w_imm_type;
                w_pc_write = 1'b1;
                if (w_is_op || w_is_op_imm || w_is_lui || w_is_auipc) begin
                    w_rf_we = 1'b1;
                end else if (w_is_load) begin
                    w_rf_we  = 1'b1;
                    w_wb_sel = WB_MEM;
                end else if (w_is_branch && r_branch_taken) begin
                    w_pc_src_sel = PC_SRC_ALU;
                    w_alu_a_sel  = A_PC;
                    w_alu_b_sel  = B_IMM;
                end else if (w_is_jal) begin
                    w_rf_we      = 1'b1;
                    w_wb_sel     = WB_PC4;
                    w_alu_a_sel  = A_PC;
                    w_alu_b_sel  = B_IMM;
                    w_pc_src_sel = PC_SRC_ALU;
                end else if (w_is_jalr) begin
                    // Datapath clears bit 0 of the target
                    w_rf_we      = 1'b1;
                    w_wb_sel     = WB_PC4;
                    w_alu_a_sel  = A_RS1;
                    w_alu_b_sel  = B_IMM;
                    w_pc_src_sel = PC_SRC_ALU;
                end
            end
            default: begin
            end
        endcase
        w_ir_write = (r_state == S_FETCH) && !r_abort && !w_timeout && mem_ready_i;
    end

    // Outputs are forced low while RESET_N is asserted so that an
    // in-flight request drops without waiting for a clock edge
    assign mem_req_o      = RESET_N & w_mem_req;
    assign mem_we_o       = RESET_N & w_mem_we;
    assign mem_addr_sel_o = RESET_N & w_mem_addr_sel;
    assign ir_write_o     = RESET_N & w_ir_write;
    assign pc_write_o     = RESET_N & w_pc_write;
    assign pc_src_sel_o   = RESET_N & w_pc_src_sel;
    assign alu_opcode_o   = RESET_N ? w_alu_opcode : 4'd0;
    assign alu_a_sel_o    = RESET_N ? w_alu_a_sel : 2'd0;
    assign alu_b_sel_o    = RESET_N ? w_alu_b_sel : 2'd0;
    assign imm_sel_o      = RESET_N ? w_imm_sel : 3'd0;
    assign rf_we_o        = RESET_N & w_rf_we;
    assign wb_sel_o       = RESET_N ? w_wb_sel : 2'd0;
    assign mem_err_o      = RESET_N & w_timeout;
    assign state_o        = RESET_N ? r_state : 3'd0;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_core_ctrl_fsm
//
// Directed bench for core_ctrl_fsm (MEM_TIMEOUT = 16). Walks a fixed set of
// RV32I instructions through the controller one cycle at a time and compares
// every output, packed into one vector, against hand-computed values.
// ---------------------------------------------------------------------------
module tb_core_ctrl_fsm;

   localparam logic [31:0] INSTR_ADD  = 32'h002081B3;
   localparam logic [31:0] INSTR_SRAI = 32'h4032D293;
   localparam logic [31:0] INSTR_ADDI = 32'hC0000093;
   localparam logic [31:0] INSTR_LW   = 32'h0080A303;
   localparam logic [31:0] INSTR_SW   = 32'h0020A223;
   localparam logic [31:0] INSTR_BEQ  = 32'h00208463;
   localparam logic [31:0] INSTR_JAL  = 32'h010000EF;
   localparam logic [31:0] INSTR_JALR = 32'h000280E7;
   localparam logic [31:0] INSTR_LUI  = 32'h12345037;
   localparam logic [31:0] INSTR_BAD  = 32'h0000007F;

   logic        clock50;
   logic        resetN;
   logic [31:0] irIn;
   logic        memReady;
   logic        branchTaken;
   logic        memReq;
   logic        memWe;
   logic        memAddrSel;
   logic        irWrite;
   logic        pcWrite;
   logic        pcSrcSel;
   logic [3:0]  aluOpcode;
   logic [1:0]  aluASel;
   logic [1:0]  aluBSel;
   logic [2:0]  immSel;
   logic        rfWe;
   logic [1:0]  wbSel;
   logic        memErr;
   logic [2:0]  stateOut;
   logic [23:0] obsVec;

   int checks = 0;
   int errors = 0;

   core_ctrl_fsm #(.MEM_TIMEOUT(16)) dut (
      .CLOCK_50       (clock50),
      .RESET_N        (resetN),
      .ir_i           (irIn),
      .mem_ready_i    (memReady),
      .branch_taken_i (branchTaken),
      .mem_req_o      (memReq),
      .mem_we_o       (memWe),
      .mem_addr_sel_o (memAddrSel),
      .ir_write_o     (irWrite),
      .pc_write_o     (pcWrite),
      .pc_src_sel_o   (pcSrcSel),
      .alu_opcode_o   (aluOpcode),
      .alu_a_sel_o    (aluASel),
      .alu_b_sel_o    (aluBSel),
      .imm_sel_o      (immSel),
      .rf_we_o        (rfWe),
      .wb_sel_o       (wbSel),
      .mem_err_o      (memErr),
      .state_o        (stateOut)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock50 = 1'b0;
      forever #5 clock50 = ~clock50;
   end

   // Every DUT output in one vector so each step is a single comparison
   assign obsVec = {memReq, memWe, memAddrSel, irWrite, pcWrite, pcSrcSel,
                    aluOpcode, aluASel, aluBSel, immSel, rfWe, wbSel, memErr, stateOut};

   function automatic logic [23:0] pack(int req, int we, int addr, int irw, int pcw, int pcs,
                                        int alu, int a, int b, int imm, int rfw, int wb,
                                        int err, int st);
      return {1'(req), 1'(we), 1'(addr), 1'(irw), 1'(pcw), 1'(pcs), 4'(alu), 2'(a), 2'(b),
              3'(imm), 1'(rfw), 2'(wb), 1'(err), 3'(st)};
   endfunction

   // Drive inputs just after a falling edge, then let outputs settle
   task automatic applyStimulus(input logic [31:0] ir, input logic ready, input logic taken);
      @(negedge clock50);
      irIn        = ir;
      memReady    = ready;
      branchTaken = taken;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [23:0] expected);
      checks++;
      assert (obsVec === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %06h expected %06h", tag, obsVec, expected);
      end
   endtask

   initial begin
      resetN      = 1'b0;
      irIn        = 32'd0;
      memReady    = 1'b0;
      branchTaken = 1'b0;

      // Reset holds everything low even though the state is FETCH
      applyStimulus(INSTR_ADD, 1'b1, 1'b0);
      checkOutput("reset outputs", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0));

      @(negedge clock50);
      resetN   = 1'b1;
      memReady = 1'b0;
      #1;
      checkOutput("fetch idle after reset", pack(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

      // ADD: 4 cycles, FETCH DECODE EXECUTE WB
      applyStimulus(INSTR_ADD, 1'b1, 1'b0); checkOutput("add fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("add decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("add exec",   pack(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("add wb",     pack(0,0,0,0,1,0,0,0,0,0,1,0,0,4));

      // SRAI keeps funct7[5] in the ALU opcode
      applyStimulus(INSTR_SRAI, 1'b1, 1'b0); checkOutput("srai fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_SRAI, 1'b0, 1'b0); checkOutput("srai decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_SRAI, 1'b0, 1'b0); checkOutput("srai exec",   pack(0,0,0,0,0,0,'b1101,0,1,0,0,0,0,2));
      applyStimulus(INSTR_SRAI, 1'b0, 1'b0); checkOutput("srai wb",     pack(0,0,0,0,1,0,0,0,0,0,1,0,0,4));

      // ADDI with imm bit 30 set must still be ADD
      applyStimulus(INSTR_ADDI, 1'b1, 1'b0); checkOutput("addi fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_ADDI, 1'b0, 1'b0); checkOutput("addi decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_ADDI, 1'b0, 1'b0); checkOutput("addi exec",   pack(0,0,0,0,0,0,0,0,1,0,0,0,0,2));
      applyStimulus(INSTR_ADDI, 1'b0, 1'b0); checkOutput("addi wb",     pack(0,0,0,0,1,0,0,0,0,0,1,0,0,4));

      // LW with three wait states in MEM: 8 cycles overall
      applyStimulus(INSTR_LW, 1'b1, 1'b0); checkOutput("lw fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("lw decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("lw exec",   pack(0,0,0,0,0,0,0,0,1,0,0,0,0,2));
      for (int i = 1; i <= 3; i++) begin
         applyStimulus(INSTR_LW, 1'b0, 1'b0);
         checkOutput($sformatf("lw mem wait %0d", i), pack(1,0,1,0,0,0,0,0,0,0,0,0,0,3));
      end
      applyStimulus(INSTR_LW, 1'b1, 1'b0); checkOutput("lw mem ready", pack(1,0,1,0,0,0,0,0,0,0,0,0,0,3));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("lw wb",        pack(0,0,0,0,1,0,0,0,0,0,1,1,0,4));

      // SW with zero-wait memory
      applyStimulus(INSTR_SW, 1'b1, 1'b0); checkOutput("sw fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_SW, 1'b0, 1'b0); checkOutput("sw decode", pack(0,0,0,0,0,0,0,0,0,1,0,0,0,1));
      applyStimulus(INSTR_SW, 1'b0, 1'b0); checkOutput("sw exec",   pack(0,0,0,0,0,0,0,0,1,1,0,0,0,2));
      applyStimulus(INSTR_SW, 1'b1, 1'b0); checkOutput("sw mem",    pack(1,1,1,0,0,0,0,0,0,1,0,0,0,3));
      applyStimulus(INSTR_SW, 1'b0, 1'b0); checkOutput("sw wb",     pack(0,0,0,0,1,0,0,0,0,1,0,0,0,4));

      // BEQ taken; comparator input flips in WB to prove it was latched
      applyStimulus(INSTR_BEQ, 1'b1, 1'b0); checkOutput("beq t fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_BEQ, 1'b0, 1'b0); checkOutput("beq t decode", pack(0,0,0,0,0,0,0,0,0,2,0,0,0,1));
      applyStimulus(INSTR_BEQ, 1'b0, 1'b1); checkOutput("beq t exec",   pack(0,0,0,0,0,0,'b1000,0,0,2,0,0,0,2));
      applyStimulus(INSTR_BEQ, 1'b0, 1'b0); checkOutput("beq t wb",     pack(0,0,0,0,1,1,0,1,1,2,0,0,0,4));

      // BEQ not taken
      applyStimulus(INSTR_BEQ, 1'b1, 1'b0); checkOutput("beq n fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_BEQ, 1'b0, 1'b0); checkOutput("beq n decode", pack(0,0,0,0,0,0,0,0,0,2,0,0,0,1));
      applyStimulus(INSTR_BEQ, 1'b0, 1'b0); checkOutput("beq n exec",   pack(0,0,0,0,0,0,'b1000,0,0,2,0,0,0,2));
      applyStimulus(INSTR_BEQ, 1'b0, 1'b1); checkOutput("beq n wb",     pack(0,0,0,0,1,0,0,0,0,2,0,0,0,4));

      // JAL and JALR
      applyStimulus(INSTR_JAL, 1'b1, 1'b0);  checkOutput("jal fetch",   pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_JAL, 1'b0, 1'b0);  checkOutput("jal decode",  pack(0,0,0,0,0,0,0,0,0,4,0,0,0,1));
      applyStimulus(INSTR_JAL, 1'b0, 1'b0);  checkOutput("jal exec",    pack(0,0,0,0,0,0,0,0,0,4,0,0,0,2));
      applyStimulus(INSTR_JAL, 1'b0, 1'b0);  checkOutput("jal wb",      pack(0,0,0,0,1,1,0,1,1,4,1,2,0,4));
      applyStimulus(INSTR_JALR, 1'b1, 1'b0); checkOutput("jalr fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_JALR, 1'b0, 1'b0); checkOutput("jalr decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_JALR, 1'b0, 1'b0); checkOutput("jalr exec",   pack(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
      applyStimulus(INSTR_JALR, 1'b0, 1'b0); checkOutput("jalr wb",     pack(0,0,0,0,1,1,0,0,1,0,1,2,0,4));

      // LUI to x0 still pulses rf_we
      applyStimulus(INSTR_LUI, 1'b1, 1'b0); checkOutput("lui fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_LUI, 1'b0, 1'b0); checkOutput("lui decode", pack(0,0,0,0,0,0,0,0,0,3,0,0,0,1));
      applyStimulus(INSTR_LUI, 1'b0, 1'b0); checkOutput("lui exec",   pack(0,0,0,0,0,0,0,2,1,3,0,0,0,2));
      applyStimulus(INSTR_LUI, 1'b0, 1'b0); checkOutput("lui wb",     pack(0,0,0,0,1,0,0,0,0,3,1,0,0,4));

      // Fetch timeout: 15 quiet waits, error on the 16th, one idle cycle
      for (int i = 1; i <= 15; i++) begin
         applyStimulus(INSTR_ADD, 1'b0, 1'b0);
         checkOutput($sformatf("timeout wait %0d", i), pack(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
      end
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("timeout error", pack(1,0,0,0,0,0,0,0,0,0,0,0,1,0));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("timeout drop",  pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_ADD, 1'b1, 1'b0); checkOutput("refetch",       pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("refetch decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("refetch exec",   pack(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
      applyStimulus(INSTR_ADD, 1'b0, 1'b0); checkOutput("refetch wb",     pack(0,0,0,0,1,0,0,0,0,0,1,0,0,4));

      // Asynchronous reset in the middle of a MEM request
      applyStimulus(INSTR_LW, 1'b1, 1'b0); checkOutput("lw2 fetch", pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("lw2 decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("lw2 exec",  pack(0,0,0,0,0,0,0,0,1,0,0,0,0,2));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("lw2 mem",   pack(1,0,1,0,0,0,0,0,0,0,0,0,0,3));
      #2 resetN = 1'b0;
      #1 checkOutput("async reset mid mem", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_LW, 1'b0, 1'b0); checkOutput("reset held", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
      @(negedge clock50);
      resetN = 1'b1;
      #1 checkOutput("fetch after mid reset", pack(1,0,0,0,0,0,0,0,0,0,0,0,0,0));

      // Unknown opcode 0x7F
      applyStimulus(INSTR_BAD, 1'b1, 1'b0); checkOutput("bad fetch",  pack(1,0,0,1,0,0,0,0,0,0,0,0,0,0));
      applyStimulus(INSTR_BAD, 1'b0, 1'b0); checkOutput("bad decode", pack(0,0,0,0,0,0,0,0,0,0,0,0,0,1));
`ifdef CORE101_ILLEGAL_TRAP_EN
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(INSTR_BAD, 1'b1, 1'b1);
         checkOutput($sformatf("trap hold %0d", i), pack(0,0,0,0,0,0,0,0,0,0,0,0,0,5));
      end
`else
      applyStimulus(INSTR_BAD, 1'b0, 1'b0); checkOutput("bad exec",   pack(0,0,0,0,0,0,0,0,0,0,0,0,0,2));
      applyStimulus(INSTR_BAD, 1'b0, 1'b0); checkOutput("bad wb",     pack(0,0,0,0,1,0,0,0,0,0,0,0,0,4));
      applyStimulus(INSTR_BAD, 1'b0, 1'b0); checkOutput("bad next fetch", pack(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
